// File: rtl/bus_grant_sequencer.sv
// Round-robin arbiter/sequencer granting the shared internal bus to one driver at a time.
// Latency: req sampled in IDLE -> grant one cycle later; release -> TURN -> IDLE before the next grant.
// Backpressure: none; a grant is held until done, the owner drops req, or the hold timeout expires.
module bus_grant_sequencer #(
   parameter int NREQ     = 32,
   parameter int SELW     = 5,
   parameter int MAX_HOLD = 16,
   parameter int CNTW     = 5
) (
   input  logic            clk,
   input  logic            clr,
   input  logic [NREQ-1:0] req,
   input  logic            done,
   output logic [NREQ-1:0] grant,
   output logic [SELW-1:0] bus_sel,
   output logic            bus_valid,
   output logic            timeout
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      TURN  = 2'd2
   } state_t;

   // Counter value on the last permitted cycle of a tenure (unused when MAX_HOLD is 0).
   localparam logic [CNTW-1:0] HOLD_LAST = CNTW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

   state_t          state;
   logic [SELW-1:0] ptr;
   logic [CNTW-1:0] cnt;

   logic [SELW-1:0] scan_idx;
   logic [SELW-1:0] pick_idx;
   logic            pick_vld;
   logic            rel_user;
   logic            rel_time;

   // Circular priority scan starting at ptr; NREQ is a power of two so index wrap is free.
   always_comb begin
      scan_idx = '0;
      pick_idx = '0;
      pick_vld = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         scan_idx = ptr + SELW'(k);
         if (!pick_vld && req[scan_idx]) begin
            pick_vld = 1'b1;
            pick_idx = scan_idx;
         end
      end
   end

   // Release causes; bus_sel doubles as the registered owner index while in GRANT.
   always_comb begin
      rel_user = done | ~req[bus_sel];
      rel_time = (MAX_HOLD != 0) && (cnt == HOLD_LAST);
   end

   // Sequencer: arbitrate in IDLE, hold in GRANT, one dead cycle in TURN.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state     <= IDLE;
         ptr       <= '0;
         cnt       <= '0;
         grant     <= '0;
         bus_sel   <= '0;
         bus_valid <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_vld) begin
                  grant     <= NREQ'(1) << pick_idx;
                  bus_sel   <= pick_idx;
                  bus_valid <= 1'b1;
                  cnt       <= '0;
                  state     <= GRANT;
               end
            end
            GRANT: begin
               if (rel_user || rel_time) begin
                  grant     <= '0;
                  bus_sel   <= '0;
                  bus_valid <= 1'b0;
                  ptr       <= bus_sel + 1'b1;
                  // A user release in the same cycle wins over the timeout flag.
                  timeout   <= rel_time && !rel_user;
                  state     <= TURN;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            TURN: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bus_grant_sequencer.sv
// Bench for bus_grant_sequencer: table vectors, hand-written corner sequences,
// and randomized traffic compared against a tenure-based reference model.
module tb_bus_grant_sequencer;

   localparam int MAX_HOLD = 16;

   logic        clk;
   logic        clr;
   logic [31:0] req;
   logic        done;
   logic [31:0] grant;
   logic [4:0]  bus_sel;
   logic        bus_valid;
   logic        timeout;

   int checks = 0;
   int errors = 0;

   bus_grant_sequencer #(.NREQ(32), .SELW(5), .MAX_HOLD(MAX_HOLD), .CNTW(5)) dut (
      .clk       (clk),
      .clr       (clr),
      .req       (req),
      .done      (done),
      .grant     (grant),
      .bus_sel   (bus_sel),
      .bus_valid (bus_valid),
      .timeout   (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1);
   end

   // ---------------- reference model: owner, tenure, dead cycles ----------------
   int m_owner;   // -1 when the bus is free
   int m_ptr;
   int m_ten;     // cycles the current owner has already held the bus
   int m_dead;    // dead cycles still to be served before arbitration resumes
   bit m_to;

   task automatic model_reset();
      m_owner = -1; m_ptr = 0; m_ten = 0; m_dead = 0; m_to = 0;
   endtask

   task automatic model_edge(input logic [31:0] r, input logic d);
      m_to = 0;
      if (m_owner >= 0) begin
         bit held;
         bit expire;
         held   = r[m_owner];
         expire = (MAX_HOLD != 0) && (m_ten == MAX_HOLD);
         if (d || !held || expire) begin
            m_to    = expire && !d && held;
            m_ptr   = (m_owner + 1) % 32;
            m_owner = -1;
            m_dead  = 1;
         end else begin
            m_ten++;
         end
      end else if (m_dead > 0) begin
         m_dead--;
      end else if (r != 0) begin
         for (int k = 0; k < 32; k++) begin
            int i;
            i = (m_ptr + k) % 32;
            if (r[i]) begin
               m_owner = i;
               m_ten   = 1;
               break;
            end
         end
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_model(input string tag);
      logic [31:0] eg;
      eg = (m_owner >= 0) ? (32'h1 << m_owner) : 32'h0;
      chk({tag, ".grant"},     grant,     eg);
      chk({tag, ".bus_sel"},   {27'd0, bus_sel}, (m_owner >= 0) ? 32'(m_owner) : 32'd0);
      chk({tag, ".bus_valid"}, {31'd0, bus_valid}, {31'd0, (m_owner >= 0)});
      chk({tag, ".timeout"},   {31'd0, timeout}, {31'd0, m_to});
   endtask

   // One clock: drive inputs just after the previous edge, sample 1 time unit after this edge.
   task automatic step(input logic [31:0] r, input logic d);
      req  = r;
      done = d;
      @(posedge clk);
      model_edge(r, d);
      #1;
      chk_model("model");
   endtask

   // Asynchronous reset pulse placed between clock edges; outputs checked before any edge.
   task automatic do_reset();
      #2;
      clr = 1'b1;
      model_reset();
      #1;
      chk("rst.grant", grant, 32'h0);
      chk("rst.bus_sel", {27'd0, bus_sel}, 32'h0);
      chk("rst.bus_valid", {31'd0, bus_valid}, 32'h0);
      chk("rst.timeout", {31'd0, timeout}, 32'h0);
      #1;
      clr = 1'b0;
   endtask

   task automatic chk_out(input string nm, input logic [31:0] g, input logic [4:0] s,
                          input logic v, input logic t);
      chk({nm, ".grant"}, grant, g);
      chk({nm, ".bus_sel"}, {27'd0, bus_sel}, {27'd0, s});
      chk({nm, ".bus_valid"}, {31'd0, bus_valid}, {31'd0, v});
      chk({nm, ".timeout"}, {31'd0, timeout}, {31'd0, t});
   endtask

   // ---------------- directed vector table ----------------
   typedef struct packed {
      logic        rst;
      logic [31:0] r;
      logic        d;
      logic [31:0] g;
      logic [4:0]  s;
      logic        v;
      logic        t;
   } vec_t;

   vec_t tbl [23];

   logic [31:0] rr;
   logic        dd;
   logic [31:0] seen;
   int          ngrant;
   int          dup;
   logic        prev_v;

   initial begin
      // single request, done three cycles after grant
      tbl[0]  = '{1'b1, 32'h0000_0010, 1'b0, 32'h0000_0010, 5'd4,  1'b1, 1'b0};
      tbl[1]  = '{1'b0, 32'h0000_0010, 1'b0, 32'h0000_0010, 5'd4,  1'b1, 1'b0};
      tbl[2]  = '{1'b0, 32'h0000_0010, 1'b0, 32'h0000_0010, 5'd4,  1'b1, 1'b0};
      tbl[3]  = '{1'b0, 32'h0000_0010, 1'b1, 32'h0,         5'd0,  1'b0, 1'b0};
      tbl[4]  = '{1'b0, 32'h0,         1'b0, 32'h0,         5'd0,  1'b0, 1'b0};
      tbl[5]  = '{1'b0, 32'h0,         1'b0, 32'h0,         5'd0,  1'b0, 1'b0};
      // round-robin wrap between 0 and 31
      tbl[6]  = '{1'b1, 32'h8000_0001, 1'b1, 32'h0000_0001, 5'd0,  1'b1, 1'b0};
      tbl[7]  = '{1'b0, 32'h8000_0001, 1'b1, 32'h0,         5'd0,  1'b0, 1'b0};
      tbl[8]  = '{1'b0, 32'h8000_0001, 1'b1, 32'h0,         5'd0,  1'b0, 1'b0};
      tbl[9]  = '{1'b0, 32'h8000_0001, 1'b1, 32'h8000_0000, 5'd31, 1'b1, 1'b0};
      tbl[10] = '{1'b0, 32'h8000_0001, 1'b1, 32'h0,         5'd0,  1'b0, 1'b0};
      tbl[11] = '{1'b0, 32'h8000_0001, 1'b1, 32'h0,         5'd0,  1'b0, 1'b0};
      tbl[12] = '{1'b0, 32'h8000_0001, 1'b1, 32'h0000_0001, 5'd0,  1'b1, 1'b0};
      tbl[13] = '{1'b0, 32'h8000_0001, 1'b1, 32'h0,         5'd0,  1'b0, 1'b0};
      tbl[14] = '{1'b0, 32'h8000_0001, 1'b1, 32'h0,         5'd0,  1'b0, 1'b0};
      tbl[15] = '{1'b0, 32'h8000_0001, 1'b1, 32'h8000_0000, 5'd31, 1'b1, 1'b0};
      tbl[16] = '{1'b0, 32'h8000_0001, 1'b1, 32'h0,         5'd0,  1'b0, 1'b0};
      tbl[17] = '{1'b0, 32'h8000_0001, 1'b1, 32'h0,         5'd0,  1'b0, 1'b0};
      tbl[18] = '{1'b0, 32'h0000_0003, 1'b0, 32'h0000_0001, 5'd0,  1'b1, 1'b0};
      // owner drops its request while a neighbour raises one
      tbl[19] = '{1'b1, 32'h0000_0020, 1'b0, 32'h0000_0020, 5'd5,  1'b1, 1'b0};
      tbl[20] = '{1'b0, 32'h0000_0040, 1'b0, 32'h0,         5'd0,  1'b0, 1'b0};
      tbl[21] = '{1'b0, 32'h0000_0040, 1'b0, 32'h0,         5'd0,  1'b0, 1'b0};
      tbl[22] = '{1'b0, 32'h0000_0040, 1'b0, 32'h0000_0040, 5'd6,  1'b1, 1'b0};

      clr  = 1'b1;
      req  = '0;
      done = 1'b0;
      model_reset();
      #1;
      chk_out("por", 32'h0, 5'd0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      clr = 1'b0;

      // idle, then reset mid-simulation with req=0, outputs stay at zero
      for (int i = 0; i < 3; i++) step(32'h0, 1'b0);
      do_reset();
      for (int i = 0; i < 3; i++) begin
         step(32'h0, 1'b0);
         chk_out("idle", 32'h0, 5'd0, 1'b0, 1'b0);
      end

      for (int i = 0; i < 23; i++) begin
         if (tbl[i].rst) do_reset();
         step(tbl[i].r, tbl[i].d);
         chk_out($sformatf("vec%0d", i), tbl[i].g, tbl[i].s, tbl[i].v, tbl[i].t);
      end

      // timeout: 16 cycles of tenure, pulse, two dead cycles, regrant
      do_reset();
      for (int i = 0; i < 16; i++) begin
         step(32'h0000_0100, 1'b0);
         chk_out("hold", 32'h0000_0100, 5'd8, 1'b1, 1'b0);
      end
      step(32'h0000_0100, 1'b0);
      chk_out("to_pulse", 32'h0, 5'd0, 1'b0, 1'b1);
      step(32'h0000_0100, 1'b0);
      chk_out("to_turn", 32'h0, 5'd0, 1'b0, 1'b0);
      step(32'h0000_0100, 1'b0);
      chk_out("to_regrant", 32'h0000_0100, 5'd8, 1'b1, 1'b0);
      // second tenure ends with done on its 16th cycle: normal release
      for (int i = 0; i < 15; i++) step(32'h0000_0100, 1'b0);
      chk_out("hold16", 32'h0000_0100, 5'd8, 1'b1, 1'b0);
      step(32'h0000_0100, 1'b1);
      chk_out("done_at_limit", 32'h0, 5'd0, 1'b0, 1'b0);

      // reset mid-grant, ptr returns to 0
      do_reset();
      step(32'h0010_0000, 1'b0);
      step(32'h0010_0000, 1'b0);
      chk_out("own20", 32'h0010_0000, 5'd20, 1'b1, 1'b0);
      do_reset();
      step(32'h0010_0002, 1'b0);
      chk_out("post_rst", 32'h0000_0002, 5'd1, 1'b1, 1'b0);

      // fairness: all 32 requesting, done never asserted
      do_reset();
      seen = '0; ngrant = 0; dup = 0; prev_v = 1'b0;
      for (int n = 0; n < 32 * 20 && ngrant < 32; n++) begin
         step(32'hFFFF_FFFF, 1'b0);
         if (bus_valid && !prev_v) begin
            if (seen[bus_sel]) dup++;
            seen[bus_sel] = 1'b1;
            ngrant++;
         end
         prev_v = bus_valid;
      end
      chk("fair.count", 32'(ngrant), 32'd32);
      chk("fair.dups", 32'(dup), 32'd0);
      chk("fair.seen", seen, 32'hFFFF_FFFF);

      // randomized traffic against the model
      rr = '0;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(7) == 0)
            rr = ($urandom_range(1) == 1) ? 32'($urandom) : (32'h1 << $urandom_range(31));
         dd = ($urandom_range(9) == 0);
         if ($urandom_range(299) == 0) do_reset();
         step(rr, dd);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bus_grant_sequencer.md
# bus_grant_sequencer

Round-robin arbiter and sequencer for the shared 32-bit internal bus. It takes one request line per bus driver (registers, PC, MDR, ALU result, etc.) and grants the bus to exactly one driver at a time. It produces a registered one-hot grant plus the matching 5-bit encoded bus select consumed by the bus multiplexer. Each grant is held until the driver releases it or a hold timeout expires, with a fixed one-cycle turnaround between owners.

## Interface
- NREQ, 32, number of requesters; fixed at 32 for the 5-bit select
- SELW, 5, width of bus_sel
- MAX_HOLD, 16, maximum consecutive cycles in GRANT; 0 disables the timeout
- CNTW, 5, hold-counter width; must satisfy 2^CNTW > MAX_HOLD
- clk  input  1  system clock, rising-edge
- clr  input  1  reset, asynchronous, active-high
- req  input  32  request lines; bit i = driver i wants the bus; level-held while wanted
- done  input  1  holder releases the bus this cycle
- grant  output  32  registered one-hot grant; all-zero when no owner
- bus_sel  output  5  registered binary index of the granted bit; 0 when no owner
- bus_valid  output  1  registered; 1 exactly when grant is nonzero
- timeout  output  1  registered one-cycle pulse when a grant is force-released

## Operation
- State machine: IDLE, GRANT, TURN. Internal state: 5-bit round-robin pointer ptr, hold counter cnt, and registered owner index.
- IDLE:
  - If req == 0, stay in IDLE.
  - Otherwise, select the first set bit of req scanning upward from ptr with circular wrap (ptr, ptr+1, …, 31, 0, …, ptr-1).
  - Load grant with the one-hot of that index, bus_sel with the index, and set bus_valid=1, cnt=0. Go to GRANT.
- GRANT: the release condition is any of:
  - done=1
  - req[owner]=0
  - MAX_HOLD≠0 and cnt==MAX_HOLD-1
- GRANT, release condition false: cnt increments. grant, bus_sel and bus_valid are unchanged.
- GRANT, release condition true:
  - Clear grant, bus_sel and bus_valid.
  - Set ptr = (owner+1) mod 32, wrapping from 31 to 0.
  - Go to TURN.
  - Pulse timeout=1 only when the timeout term is the sole cause. If done=1 or req[owner]=0 in the same cycle, it is a normal release and timeout=0.
- TURN: one dead cycle with no bus driver. Go to IDLE unconditionally. Requests are ignored in TURN.
- Request changes on non-owner bits never affect the current grant.
- Invariant: grant is always zero or one-hot; bus_sel always equals the index of the set bit, or 0 when grant is zero.
- Reset (clr=1, any time, including mid-grant): state=IDLE, ptr=0, cnt=0, grant=0, bus_sel=0, bus_valid=0, timeout=0. Reset takes effect immediately, with no clock edge needed.

## Timing
- All outputs are registered and change only on the rising edge of clk or on clr.
- Request-to-grant latency:
  - req sampled at edge E while in IDLE gives grant visible after E (one cycle).
  - A request arriving while the bus is busy waits for GRANT → TURN → IDLE.
- Release latency: a release condition present at edge E clears grant after E. bus_valid is 0 for at least 2 cycles (TURN plus the IDLE arbitration cycle) before the next owner.
- Maximum tenure: MAX_HOLD cycles with bus_valid=1. The timeout pulse coincides with the first cycle of bus_valid=0.
- Fairness: with all 32 requesting continuously and done never asserted, each index is granted exactly once in every 32 consecutive grants.

## Test plan
- Reset/idle:
  - Assert clr mid-simulation with req=0.
  - Required: grant=0, bus_sel=0, bus_valid=0, timeout=0 immediately.
  - Required: outputs stay there while req=0.
- Single request:
  - req=0x0000_0010, done pulsed 3 cycles after the grant.
  - Required: one cycle after req, grant=0x0000_0010, bus_sel=4, bus_valid=1.
  - Required: after the done edge, all outputs return to 0, with 2 cycles of bus_valid=0.
- Round-robin wrap:
  - req=0x8000_0001 held, done pulsed in every GRANT cycle, starting from ptr=0.
  - Required: bus_sel sequence 0, 31, 0, 31.
  - Required: after the owner at 31 releases, ptr wraps to 0.
- Timeout:
  - MAX_HOLD=16, req=0x0000_0100 held, done=0.
  - Required: bus_valid=1 for exactly 16 cycles with bus_sel=8.
  - Required: then timeout=1 for one cycle, then regrant of 8 after TURN and IDLE.
  - Repeat with done=1 on cycle 16: timeout stays 0.
- Owner drops request:
  - Owner 5 granted, req[5] falls while req[6] rises.
  - Required: grant clears after the edge, then grant=0x0000_0040, bus_sel=6 two cycles later.
- Reset mid-grant:
  - clr asserted while bus_sel=20.
  - Required: outputs 0 immediately.
  - Required: after release with req=0x0010_0002, first grant goes to index 1 (ptr reset to 0).
